apb_dual_timers: RTL and testbench
==================================

# apb_dual_timers

Dual 32/16-bit down-counting timer peripheral on the APB bus, register-compatible with the Arm SP804 / CMSDK dual timer. The block provides two independent timers, each with periodic, free-running and one-shot modes, a prescaler, a background load register and a maskable interrupt. It sits on the system APB as a slave and drives two individual timer interrupt lines plus a combined interrupt line to the interrupt controller.

## Interface
- No parameters.
- PCLK  in  1  single clock; all state is clocked on the rising edge.
- PRESETn  in  1  asynchronous active-low reset.
- PSEL  in  1  APB select.
- PENABLE  in  1  APB access phase.
- PADDR  in  10 ([11:2])  word address.
- PWRITE  in  1  1 = write.
- PWDATA  in  32  write data.
- TIMCLK  in  1  kept for port compatibility only; unused internally. All counting is on PCLK.
- TIMCLKEN1  in  1  count enable for timer 1, sampled on PCLK.
- TIMCLKEN2  in  1  count enable for timer 2, sampled on PCLK.
- ECOREVNUM  in  4  ECO revision, returned in PID3[7:4].
- PRDATA  out  32  read data.
- PSLVERR  out  1  tied 0.
- TIMINT1  out  1  timer 1 masked interrupt.
- TIMINT2  out  1  timer 2 masked interrupt.
- TIMINTC  out  1  TIMINT1 | TIMINT2.

## Operation
- Register map (byte offset, timer 1 / timer 2): Load 0x00/0x20 RW; Value 0x04/0x24 RO; Control 0x08/0x28 RW [7:0]; IntClr 0x0C/0x2C WO; RIS 0x10/0x30 RO [0]; MIS 0x14/0x34 RO [0]; BGLoad 0x18/0x38 RW (reads Load).
- ID registers: PID4 0xFD0=0x04, PID5–7 0xFD4–0xFDC=0x00, PID0 0xFE0=0x23, PID1 0xFE4=0xB8, PID2 0xFE8=0x1B, PID3 0xFEC={ECOREVNUM,4'h0}, CID0–3 0xFF0–0xFFC=0x0D,0xF0,0x05,0xB1. All other addresses read 0; writes to them are ignored.
- Control bits:
  - [0] OneShot.
  - [1] TimerSize: 1 = 32-bit, 0 = 16-bit.
  - [3:2] Prescale: 00 = /1, 01 = /16, 10 = /256, 11 = /256.
  - [5] IntEnable.
  - [6] Mode: 1 = periodic, 0 = free-running.
  - [7] Enable.
  - [4] reads 0; bits [31:8] read 0.
- Write to Load: updates Load and sets load-pending.
- Write to BGLoad: updates Load only. It does not touch the counter or load-pending.
- Tick: an edge where TIMCLKENx=1 and the prescaler reaches its terminal count. The prescaler is an 8-bit counter advanced on TIMCLKENx and cleared while Enable=0. With /1, every TIMCLKENx edge is a tick.
- Counter update, in priority order on an edge with TIMCLKENx=1:
  1. If load-pending: counter ← Load and load-pending is cleared. This applies regardless of Enable or prescaler.
  2. Else, if Enable=1 and tick, and the active width is nonzero: decrement the active width.
  3. Else, if Enable=1 and tick, and the active width is zero:
     - periodic → reload from Load;
     - free-running → active width set to all-ones;
     - one-shot → hold at 0 with no further interrupts until the next Load write.
- Active width is [31:0] in 32-bit mode, [15:0] in 16-bit mode. In 16-bit mode, [31:16] change only on a load from Load.
- RIS: set on the edge where a decrement makes the active width 0. Cleared by any write to IntClr. If set and clear happen on the same edge, set wins.
- MIS = RIS & IntEnable. TIMINTx = MISx.
- APB write: takes effect on the PCLK edge with PSEL & PWRITE & PENABLE.
- APB read: PRDATA is combinational from registers while PSEL & !PWRITE, otherwise 0. No wait states.

## Timing
- Reset values:
  - Load 0, Value 0xFFFFFFFF, Control 0x20, RIS 0, load-pending 0, prescalers 0.
  - TIMINT1/2/C 0, PRDATA 0, PSLVERR 0.
- Reset asserted mid-count returns all state to these values immediately.
- Load write at edge N with TIMCLKEN high: Value = Load at N+1, Load−1 at N+2, and so on.
- With /1 and a continuous enable, RIS rises at N+1+Load. The counter reaches 0 there.
- The edge after 0 reloads or wraps. The periodic interrupt period is therefore Load+1 ticks.
- Load=0 in periodic mode: reloads 0 every tick; RIS never sets from the decrement rule.
- Interrupt outputs follow RIS/IntEnable combinationally: no extra cycle.
- Timers are fully independent. Simultaneous APB write to one timer and a tick of the other is legal.

## Test plan
- After reset, read Control1 → 0x20, Value1 → 0xFFFFFFFF, PID3 with ECOREVNUM=5 → 0x50, CID0 → 0x0D; TIMINTC=0.
- TIMCLKEN1/2=1; Control1 and Control2 = 0xA0; Load1=30; Load2=70 → Value1 counts 30→0, TIMINT1 asserts 31 cycles after the Load1 write edge, then Value1 wraps to 0x0000FFFF. Same pattern on timer 2 with 71 cycles. TIMINTC=1 while either is set.
- BGLoad1=90 after the previous scenario → Value1 continues its current count unchanged, Load1 reads 90. Periodic mode (Control 0xE0) then reloads 90 at the next zero.
- Write IntClr1 → TIMINT1 drops next cycle, RIS2 unaffected. Write IntClr1 on the same edge RIS1 sets → RIS1 stays 1.
- One-shot 32-bit (Control 0xA3), Load=5 → Value reaches 0 after 6 cycles, TIMINT1=1, Value stays 0. Control=0x83 → RIS1 reads 1, TIMINT1=0.
- Prescale /16 (Control 0xE6), Load=2 → Value decrements every 16 enabled cycles. TIMCLKEN1=0 freezes the count. PRESETn pulse mid-count → all reset values restored.

Source files
------------

// File: rtl/apb_dual_timers.sv
// apb_dual_timers: two independent SP804/CMSDK-compatible down-counting timers
// on an APB slave port, with per-timer and combined interrupt outputs.

// ---------------------------------------------------------------------------
// One timer channel: load/background-load register, control register,
// prescaler, 32/16-bit down counter and raw/masked interrupt status.
// ---------------------------------------------------------------------------
module apb_dual_timers_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        timclken_i,
  input  logic        wr_load_i,
  input  logic        wr_bgload_i,
  input  logic        wr_ctrl_i,
  input  logic        wr_intclr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_o,
  output logic [31:0] value_o,
  output logic [7:0]  ctrl_o,
  output logic        ris_o,
  output logic        mis_o
);

  // Control register layout, MSB first.
  typedef struct packed {
    logic       enable;    // [7]
    logic       periodic;  // [6] 1 = periodic, 0 = free-running
    logic       int_en;    // [5]
    logic       rsvd;      // [4] always reads 0
    logic [1:0] prescale;  // [3:2] 00 /1, 01 /16, 1x /256
    logic       size32;    // [1] 1 = 32-bit, 0 = 16-bit
    logic       one_shot;  // [0]
  } ctrl_t;

  localparam ctrl_t CTRL_RESET = ctrl_t'(8'h20);

  logic [31:0] load_q,  load_d;
  logic [31:0] value_q, value_d;
  ctrl_t       ctrl_q,  ctrl_d;
  logic [7:0]  presc_q, presc_d;
  logic        ris_q,   ris_d;
  logic        pend_q,  pend_d;

  logic        presc_term;
  logic        tick;
  logic        active_zero;
  logic        set_ris;

  // Prescaler: advances on each enabled TIMCLKEN edge, held clear while disabled.
  // NOTE: every variable assigned in an always_comb gets a default first, so no path can leave it unassigned and infer a latch.
  always_comb begin
    presc_d = presc_q;
    if (!ctrl_q.enable) begin
      presc_d = 8'd0;
    end else if (timclken_i) begin
      presc_d = presc_q + 8'd1;
    end
  end

  // Terminal-count detect for the selected division ratio.
  always_comb begin
    presc_term = 1'b1;
    case (ctrl_q.prescale)
      2'b00:   presc_term = 1'b1;
      2'b01:   presc_term = (presc_q[3:0] == 4'hF);
      default: presc_term = (presc_q == 8'hFF);
    endcase
  end

  assign tick        = timclken_i & ctrl_q.enable & presc_term;
  assign active_zero = ctrl_q.size32 ? (value_q == 32'd0) : (value_q[15:0] == 16'd0);

  // Counter next state: pending load beats decrement, which beats the zero action.
  always_comb begin
    value_d = value_q;
    pend_d  = pend_q;
    set_ris = 1'b0;
    if (timclken_i) begin
      if (pend_q) begin
        value_d = load_q;
        pend_d  = 1'b0;
      end else if (tick) begin
        if (!active_zero) begin
          if (ctrl_q.size32) begin
            value_d = value_q - 32'd1;
            set_ris = (value_q == 32'd1);
          end else begin
            value_d[15:0] = value_q[15:0] - 16'd1;
            set_ris       = (value_q[15:0] == 16'd1);
          end
        end else if (ctrl_q.one_shot) begin
          // Expired one-shot: hold at zero until software writes Load again.
          value_d = value_q;
        end else if (ctrl_q.periodic) begin
          value_d = load_q;
        end else if (ctrl_q.size32) begin
          value_d = 32'hFFFF_FFFF;
        end else begin
          value_d[15:0] = 16'hFFFF;
        end
      end
    end
    // A Load write arms a reload; it wins over the pending clear on the same edge.
    if (wr_load_i) begin
      pend_d = 1'b1;
    end
  end

  // Register writes and interrupt status; a new interrupt beats a same-edge clear.
  always_comb begin
    load_d = load_q;
    ctrl_d = ctrl_q;
    if (wr_load_i || wr_bgload_i) begin
      load_d = wdata_i;
    end
    if (wr_ctrl_i) begin
      ctrl_d = ctrl_t'(wdata_i[7:0] & 8'hEF);
    end
    ris_d = set_ris | (ris_q & ~wr_intclr_i);
  end

  // State registers.
  // NOTE: every flop, including the 32-bit load and value registers, has a reset value because software reads them straight after reset.
  // NOTE: sequential state is updated with non-blocking assignments so all flops sample the pre-edge values together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_q  <= 32'd0;
      value_q <= 32'hFFFF_FFFF;
      ctrl_q  <= CTRL_RESET;
      presc_q <= 8'd0;
      ris_q   <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      load_q  <= load_d;
      value_q <= value_d;
      ctrl_q  <= ctrl_d;
      presc_q <= presc_d;
      ris_q   <= ris_d;
      pend_q  <= pend_d;
    end
  end

  assign load_o  = load_q;
  assign value_o = value_q;
  assign ctrl_o  = ctrl_q;
  assign ris_o   = ris_q;
  assign mis_o   = ris_q & ctrl_q.int_en;

endmodule

// ---------------------------------------------------------------------------
// Top level: APB decode, read mux, ID registers and interrupt outputs.
// ---------------------------------------------------------------------------
module apb_dual_timers (
  input  logic        PCLK,
  input  logic        PRESETn,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic [11:2] PADDR,
  input  logic        PWRITE,
  input  logic [31:0] PWDATA,
  input  logic        TIMCLK,
  input  logic        TIMCLKEN1,
  input  logic        TIMCLKEN2,
  input  logic [3:0]  ECOREVNUM,
  output logic [31:0] PRDATA,
  output logic        PSLVERR,
  output logic        TIMINT1,
  output logic        TIMINT2,
  output logic        TIMINTC
);

  // Register index within a timer's 8-word window.
  typedef enum logic [2:0] {
    REG_LOAD   = 3'd0,
    REG_VALUE  = 3'd1,
    REG_CTRL   = 3'd2,
    REG_INTCLR = 3'd3,
    REG_RIS    = 3'd4,
    REG_MIS    = 3'd5,
    REG_BGLOAD = 3'd6,
    REG_NONE   = 3'd7
  } reg_idx_t;

  // TIMCLK is a compatibility-only pin; counting runs on PCLK.
  logic unused_timclk;
  assign unused_timclk = TIMCLK;

  logic        wr_en;
  logic        timer_win;
  logic        id_win;
  reg_idx_t    reg_idx;
  logic [1:0]  wr_timer;
  logic [31:0] rdata;

  logic [31:0] load1, value1, load2, value2;
  logic [7:0]  ctrl1, ctrl2;
  logic        ris1, mis1, ris2, mis2;

  assign wr_en     = PSEL & PWRITE & PENABLE;
  assign timer_win = (PADDR[11:6] == 6'h00);
  assign id_win    = (PADDR[11:6] == 6'h3F);
  assign reg_idx   = reg_idx_t'(PADDR[4:2]);
  assign wr_timer  = {wr_en & timer_win & PADDR[5], wr_en & timer_win & ~PADDR[5]};

  apb_dual_timers_unit u_timer1 (
    .clk         (PCLK),
    .rst_n       (PRESETn),
    .timclken_i  (TIMCLKEN1),
    .wr_load_i   (wr_timer[0] && (reg_idx == REG_LOAD)),
    .wr_bgload_i (wr_timer[0] && (reg_idx == REG_BGLOAD)),
    .wr_ctrl_i   (wr_timer[0] && (reg_idx == REG_CTRL)),
    .wr_intclr_i (wr_timer[0] && (reg_idx == REG_INTCLR)),
    .wdata_i     (PWDATA),
    .load_o      (load1),
    .value_o     (value1),
    .ctrl_o      (ctrl1),
    .ris_o       (ris1),
    .mis_o       (mis1)
  );

  apb_dual_timers_unit u_timer2 (
    .clk         (PCLK),
    .rst_n       (PRESETn),
    .timclken_i  (TIMCLKEN2),
    .wr_load_i   (wr_timer[1] && (reg_idx == REG_LOAD)),
    .wr_bgload_i (wr_timer[1] && (reg_idx == REG_BGLOAD)),
    .wr_ctrl_i   (wr_timer[1] && (reg_idx == REG_CTRL)),
    .wr_intclr_i (wr_timer[1] && (reg_idx == REG_INTCLR)),
    .wdata_i     (PWDATA),
    .load_o      (load2),
    .value_o     (value2),
    .ctrl_o      (ctrl2),
    .ris_o       (ris2),
    .mis_o       (mis2)
  );

  // Combinational read mux; idle bus and unmapped addresses read zero.
  always_comb begin
    rdata = 32'd0;
    if (PSEL && !PWRITE) begin
      if (timer_win) begin
        case (reg_idx)
          REG_LOAD,
          REG_BGLOAD: rdata = PADDR[5] ? load2 : load1;
          REG_VALUE:  rdata = PADDR[5] ? value2 : value1;
          REG_CTRL:   rdata = {24'd0, (PADDR[5] ? ctrl2 : ctrl1)};
          REG_RIS:    rdata = {31'd0, (PADDR[5] ? ris2 : ris1)};
          REG_MIS:    rdata = {31'd0, (PADDR[5] ? mis2 : mis1)};
          default:    rdata = 32'd0;
        endcase
      end else if (id_win) begin
        case (PADDR[5:2])
          4'h4:    rdata = 32'h0000_0004;
          4'h8:    rdata = 32'h0000_0023;
          4'h9:    rdata = 32'h0000_00B8;
          4'hA:    rdata = 32'h0000_001B;
          4'hB:    rdata = {24'd0, ECOREVNUM, 4'h0};
          4'hC:    rdata = 32'h0000_000D;
          4'hD:    rdata = 32'h0000_00F0;
          4'hE:    rdata = 32'h0000_0005;
          4'hF:    rdata = 32'h0000_00B1;
          default: rdata = 32'd0;
        endcase
      end
    end
  end

  assign PRDATA  = rdata;
  assign PSLVERR = 1'b0;
  assign TIMINT1 = mis1;
  assign TIMINT2 = mis2;
  assign TIMINTC = mis1 | mis2;

endmodule

// File: tb/tb_apb_dual_timers.sv
// Self-checking bench for apb_dual_timers: register reads go through a
// scoreboard queue; timing is tracked with a free-running edge counter.
module tb_apb_dual_timers;

  logic        PCLK = 1'b0;
  logic        PRESETn;
  logic        PSEL;
  logic        PENABLE;
  logic [11:2] PADDR;
  logic        PWRITE;
  logic [31:0] PWDATA;
  logic        TIMCLK;
  logic        TIMCLKEN1;
  logic        TIMCLKEN2;
  logic [3:0]  ECOREVNUM;
  logic [31:0] PRDATA;
  logic        PSLVERR;
  logic        TIMINT1;
  logic        TIMINT2;
  logic        TIMINTC;

  apb_dual_timers dut (
    .PCLK      (PCLK),
    .PRESETn   (PRESETn),
    .PSEL      (PSEL),
    .PENABLE   (PENABLE),
    .PADDR     (PADDR),
    .PWRITE    (PWRITE),
    .PWDATA    (PWDATA),
    .TIMCLK    (TIMCLK),
    .TIMCLKEN1 (TIMCLKEN1),
    .TIMCLKEN2 (TIMCLKEN2),
    .ECOREVNUM (ECOREVNUM),
    .PRDATA    (PRDATA),
    .PSLVERR   (PSLVERR),
    .TIMINT1   (TIMINT1),
    .TIMINT2   (TIMINT2),
    .TIMINTC   (TIMINTC)
  );

  always #50 PCLK = ~PCLK;

  // Rising-edge count; at a falling edge it equals the number of edges seen.
  int cyc = 0;
  always @(posedge PCLK) cyc <= cyc + 1;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } sb_item_t;

  sb_item_t sb_q[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (edge %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Read: expectation queued as the access is driven, compared when PRDATA settles.
  task automatic rd(input string tag, input logic [11:0] addr, input logic [31:0] exp);
    sb_item_t it;
    sb_q.push_back('{tag, exp});
    PSEL = 1'b1; PWRITE = 1'b0; PENABLE = 1'b1; PADDR = addr[11:2];
    #1;
    it = sb_q.pop_front();
    check(it.tag, PRDATA, it.exp);
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  // Two-phase APB write; called at a falling edge, returns at the falling
  // edge right after the rising edge on which the write takes effect.
  task automatic apb_write(input logic [11:0] addr, input logic [31:0] data);
    PSEL = 1'b1; PWRITE = 1'b1; PENABLE = 1'b0; PADDR = addr[11:2]; PWDATA = data;
    @(posedge PCLK);
    @(negedge PCLK);
    PENABLE = 1'b1;
    @(posedge PCLK);
    @(negedge PCLK);
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic step_to(input int target);
    if (cyc > target) begin
      $display("FAIL step_to: at edge %0d, already past %0d", cyc, target);
      $fatal(1, "schedule overrun");
    end
    while (cyc < target) @(negedge PCLK);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached at edge %0d", cyc);
    $fatal(1, "watchdog");
  end

  int n1, n2, l, e, f;

  initial begin
    PRESETn = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PADDR = '0; PWRITE = 1'b0;
    PWDATA = '0; TIMCLK = 1'b0; TIMCLKEN1 = 1'b1; TIMCLKEN2 = 1'b1; ECOREVNUM = 4'd5;
    repeat (3) @(negedge PCLK);
    PRESETn = 1'b1;
    @(negedge PCLK);

    // Reset state and ID registers
    check("prdata_idle", PRDATA, 32'h0);
    check("pslverr", {31'd0, PSLVERR}, 32'h0);
    check("timintc_rst", {31'd0, TIMINTC}, 32'h0);
    rd("ctrl1_rst",  12'h008, 32'h20);
    rd("value1_rst", 12'h004, 32'hFFFF_FFFF);
    rd("load1_rst",  12'h000, 32'h0);
    rd("ctrl2_rst",  12'h028, 32'h20);
    rd("pid3",       12'hFEC, 32'h50);
    rd("cid0",       12'hFF0, 32'h0D);
    rd("pid0",       12'hFE0, 32'h23);
    rd("unmapped",   12'h040, 32'h0);

    // Free-running 16-bit on both timers
    apb_write(12'h008, 32'hA0);
    apb_write(12'h028, 32'hA0);
    apb_write(12'h000, 32'd30); n1 = cyc;
    apb_write(12'h020, 32'd70); n2 = cyc;
    rd("v1_n1+2", 12'h004, 32'd29);
    step_to(n1 + 30);
    rd("v1_n1+30", 12'h004, 32'd1);
    check("timint1_pre", {31'd0, TIMINT1}, 32'h0);
    step_to(n1 + 31);
    rd("v1_zero", 12'h004, 32'd0);
    check("timint1_set", {31'd0, TIMINT1}, 32'h1);
    check("timintc_t1", {31'd0, TIMINTC}, 32'h1);
    rd("ris1", 12'h010, 32'h1);
    rd("mis1", 12'h014, 32'h1);
    step_to(n1 + 32);
    rd("v1_wrap", 12'h004, 32'h0000_FFFF);
    rd("v2_mid",  12'h024, 32'd41);
    step_to(n2 + 70);
    rd("v2_pre", 12'h024, 32'd1);
    check("timint2_pre", {31'd0, TIMINT2}, 32'h0);
    step_to(n2 + 71);
    rd("v2_zero", 12'h024, 32'd0);
    check("timint2_set", {31'd0, TIMINT2}, 32'h1);
    rd("v1_free", 12'h004, 32'h0000_FFD6);
    step_to(n2 + 72);
    rd("v2_wrap", 12'h024, 32'h0000_FFFF);

    // IntClr1 leaves timer 2 alone
    apb_write(12'h00C, 32'h0);
    check("timint1_clr", {31'd0, TIMINT1}, 32'h0);
    rd("ris1_clr", 12'h010, 32'h0);
    rd("ris2_kept", 12'h030, 32'h1);
    check("timintc_t2", {31'd0, TIMINTC}, 32'h1);

    // Periodic with a background load mid-count
    apb_write(12'h008, 32'hE0);
    apb_write(12'h000, 32'd20); l = cyc;
    step_to(l + 5);
    rd("v1_l+5", 12'h004, 32'd16);
    apb_write(12'h018, 32'd90);
    rd("v1_bg", 12'h004, 32'd14);
    rd("load1_bg", 12'h000, 32'd90);
    rd("bgload1", 12'h018, 32'd90);
    step_to(l + 21);
    rd("v1_per0", 12'h004, 32'd0);
    check("timint1_per", {31'd0, TIMINT1}, 32'h1);
    step_to(l + 22);
    rd("v1_reload", 12'h004, 32'd90);
    apb_write(12'h00C, 32'h0);
    check("timint1_clr2", {31'd0, TIMINT1}, 32'h0);
    step_to(l + 110);
    apb_write(12'h00C, 32'h0);
    rd("ris1_setwins", 12'h010, 32'h1);
    rd("v1_per0b", 12'h004, 32'd0);
    step_to(l + 113);
    rd("v1_reload2", 12'h004, 32'd90);

    // One-shot 32-bit
    apb_write(12'h00C, 32'h0);
    apb_write(12'h008, 32'hA3);
    apb_write(12'h000, 32'd5); l = cyc;
    step_to(l + 5);
    rd("os_v1", 12'h004, 32'd1);
    check("os_int_pre", {31'd0, TIMINT1}, 32'h0);
    step_to(l + 6);
    rd("os_v0", 12'h004, 32'd0);
    check("os_int", {31'd0, TIMINT1}, 32'h1);
    step_to(l + 12);
    rd("os_hold", 12'h004, 32'd0);
    apb_write(12'h008, 32'h83);
    rd("os_ris", 12'h010, 32'h1);
    rd("os_mis", 12'h014, 32'h0);
    check("os_masked", {31'd0, TIMINT1}, 32'h0);
    rd("ctrl1_83", 12'h008, 32'h83);

    // Timer 2: periodic with Load=0 never raises an interrupt; bit 4 reads 0
    apb_write(12'h02C, 32'h0);
    check("timint2_clr", {31'd0, TIMINT2}, 32'h0);
    apb_write(12'h028, 32'hF0);
    rd("ctrl2_bit4", 12'h028, 32'hE0);
    apb_write(12'h020, 32'd0); l = cyc;
    step_to(l + 10);
    rd("v2_load0", 12'h024, 32'd0);
    rd("ris2_load0", 12'h030, 32'h0);

    // Prescale /16 and TIMCLKEN1 freeze
    apb_write(12'h00C, 32'h0);
    apb_write(12'h008, 32'h06);
    apb_write(12'h000, 32'd2);
    apb_write(12'h008, 32'hE6); e = cyc;
    rd("ps_start", 12'h004, 32'd2);
    step_to(e + 15);
    rd("ps_e+15", 12'h004, 32'd2);
    step_to(e + 16);
    rd("ps_e+16", 12'h004, 32'd1);
    TIMCLKEN1 = 1'b0;
    step_to(e + 56);
    rd("ps_frozen", 12'h004, 32'd1);
    f = cyc;
    TIMCLKEN1 = 1'b1;
    step_to(f + 15);
    rd("ps_f+15", 12'h004, 32'd1);
    check("ps_int_pre", {31'd0, TIMINT1}, 32'h0);
    step_to(f + 16);
    rd("ps_f+16", 12'h004, 32'd0);
    check("ps_int", {31'd0, TIMINT1}, 32'h1);

    // Reset pulse mid-count
    step_to(f + 20);
    PRESETn = 1'b0;
    #1;
    check("rst_timint1", {31'd0, TIMINT1}, 32'h0);
    check("rst_timintc", {31'd0, TIMINTC}, 32'h0);
    rd("rst_value1", 12'h004, 32'hFFFF_FFFF);
    rd("rst_ctrl1",  12'h008, 32'h20);
    rd("rst_load1",  12'h000, 32'h0);
    rd("rst_ris1",   12'h010, 32'h0);
    rd("rst_value2", 12'h024, 32'hFFFF_FFFF);
    rd("rst_ctrl2",  12'h028, 32'h20);
    repeat (2) @(negedge PCLK);
    PRESETn = 1'b1;
    @(negedge PCLK);
    rd("post_value1", 12'h004, 32'hFFFF_FFFF);
    rd("post_load2",  12'h020, 32'h0);
    check("sb_empty", sb_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
